logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
Parametrised, pipelined successor to the 8-bit combinational logic unit. It performs bitwise operations and signed/unsigned compares on DATA_WIDTH operands. Operands enter and results leave through valid/ready handshakes on both sides, with two register stages between them. It sits between the ALU operand-select stage and the ALU result mux, and also keeps a saturating count of completed operations for performance monitoring.

Parameters:
DATA_WIDTH, 8, operand and result width in bits; legal range is 2 to 64.
COUNT_WIDTH, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block accepts an operand beat this cycle.
in_a  input  DATA_WIDTH  operand A.
in_b  input  DATA_WIDTH  operand B.
in_op  input  4  opcode; encoding is given under Behaviour.
out_valid  output  1  result beat valid.
out_ready  input  1  downstream accepts the result beat.
out_data  output  DATA_WIDTH  result.
out_flag  output  3  compare flags {greater, equal, lower}.
out_zero  output  1  out_data is all zeros.
out_err  output  1  illegal opcode was issued.
op_count  output  COUNT_WIDTH  saturating count of result beats accepted downstream.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: while rst_n is low, every register clears to 0. Outputs out_valid, out_data, out_flag, out_zero, out_err and op_count are all 0. in_ready is forced to 0.
- Opcode encoding:
  - 0x0 CPR: unsigned compare.
  - 0x1 AND.
  - 0x2 OR.
  - 0x3 XOR.
  - 0x4 NOTA: ~a.
  - 0x5 NOTB: ~b.
  - 0x6 NAND.
  - 0x7 NOR.
  - 0x8 XNOR.
  - 0x9 CPRS: two's-complement signed compare.
  - 0xA ANDN: a & ~b.
  - 0xB–0xF: illegal.
- Compare opcodes (CPR, CPRS):
  - out_data is 0.
  - out_flag is one-hot: 100 when a>b, 010 when a==b, 001 when a<b.
  - out_zero is 1.
- Non-compare opcodes: out_flag is 000; out_zero equals (out_data == 0).
- Illegal opcodes: out_data, out_flag and out_zero are all 0; out_err is 1. The beat still flows through the pipeline and still counts.
- Stage 1 (S1) registers a, b and op, with valid bit s1_v. Stage 2 (S2) registers the computed result and flags, with valid bit s2_v. All outputs come directly from S2 registers.
- Latency: 2 cycles from the in_valid&&in_ready edge to out_valid, provided there is no backpressure. Throughput is 1 beat per cycle.
- Advance rules:
  - s2_adv = !s2_v || out_ready.
  - s1_adv = !s1_v || s2_adv.
  - in_ready = rst_n && s1_adv. A combinational path from out_ready to in_ready is permitted.
- Register updates:
  - When s2_adv, S2 loads the result computed from S1 and s2_v <= s1_v.
  - When s1_adv, S1 loads the input beat and s1_v <= in_valid.
  - Registers that are not advancing hold their value.
- Output stability: while out_valid && !out_ready, out_data, out_flag, out_zero and out_err are held stable.
- Simultaneous events: when the pipeline is full and out_ready=1, accept, shift and emit all happen in the same cycle with no bubble.
- op_count:
  - Increments by 1 on every out_valid && out_ready.
  - Saturates at 2^COUNT_WIDTH-1 and never wraps.
- Reset mid-operation: in-flight beats are discarded and op_count clears. No beat is emitted after reset deasserts until a new one has been accepted.
- Width rules: operations are strictly DATA_WIDTH wide with no carry out. For CPRS, bit DATA_WIDTH-1 is the sign bit.

Optional Feature:
Macro: LOGIC_UNIT_PARITY_EN.
- When defined:
  - Adds output port out_parity (output, 1 bit). It is registered in S2 and equals the XOR-reduction of out_data (even parity). For compare and illegal opcodes it is 0. Its reset value is 0, and it is held under backpressure like the other outputs.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then a=0xC3, b=0x5A, op=AND with out_ready=1. Expect out_valid exactly 2 cycles after acceptance, out_data=0x42, flag=000, zero=0, op_count=1.
- op=CPR with a=0x80, b=0x01 → flag=100. Same operands with op=CPRS → flag=001. a=b=0x7F with op=CPRS → flag=010. In all three cases out_data=0 and zero=1.
- Stream 5 back-to-back beats (XOR, NOR, XNOR, NOTA, ANDN on a=0xF0, b=0x3C) with out_ready low for cycles 2–5:
  - in_ready drops when both stages are full.
  - No beat is lost or duplicated.
  - Results appear in order: 0xCC, 0x03, 0x33, 0x0F, 0xC0.
  - Outputs stay stable while stalled.
- op=0xD → out_err=1, out_data=0, flag=000, zero=0, and op_count still increments. The next legal beat has out_err=0.
- Assert rst_n low while 2 beats are in flight → outputs and op_count go to 0 immediately; after release, no stale out_valid appears.
- With COUNT_WIDTH=3, complete 10 beats → op_count reads 7 and stays 7. With LOGIC_UNIT_PARITY_EN defined, op=OR, a=0x01, b=0x02 → out_parity=0; a=0x07, b=0x00 → out_parity=1.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage valid/ready bitwise and compare unit with saturating op counter
// Optional even-parity output out_parity is built only when LOGIC_UNIT_PARITY_EN is defined.

module logic_unit_pipe #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_a,
   input  logic [DATA_WIDTH-1:0]  in_b,
   input  logic [3:0]             in_op,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [2:0]             out_flag,
   output logic                   out_zero,
   output logic                   out_err,
   output logic [COUNT_WIDTH-1:0] op_count
`ifdef LOGIC_UNIT_PARITY_EN
   ,
   output logic                   out_parity
`endif
);

   localparam logic [3:0] OP_CPR  = 4'h0;
   localparam logic [3:0] OP_AND  = 4'h1;
   localparam logic [3:0] OP_OR   = 4'h2;
   localparam logic [3:0] OP_XOR  = 4'h3;
   localparam logic [3:0] OP_NOTA = 4'h4;
   localparam logic [3:0] OP_NOTB = 4'h5;
   localparam logic [3:0] OP_NAND = 4'h6;
   localparam logic [3:0] OP_NOR  = 4'h7;
   localparam logic [3:0] OP_XNOR = 4'h8;
   localparam logic [3:0] OP_CPRS = 4'h9;
   localparam logic [3:0] OP_ANDN = 4'hA;

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

   logic                   s1_v;
   logic [DATA_WIDTH-1:0]  s1_a;
   logic [DATA_WIDTH-1:0]  s1_b;
   logic [3:0]             s1_op;

   logic                   s2_v;
   logic [DATA_WIDTH-1:0]  s2_data;
   logic [2:0]             s2_flag;
   logic                   s2_zero;
   logic                   s2_err;
   logic [COUNT_WIDTH-1:0] cnt;

   logic                   s1_adv;
   logic                   s2_adv;
   logic                   out_fire;

   logic [DATA_WIDTH-1:0]  res_data;
   logic [2:0]             res_flag;
   logic                   res_zero;
   logic                   res_err;
   logic                   res_cmp;

   assign s2_adv   = !s2_v || out_ready;
   assign s1_adv   = !s1_v || s2_adv;
   assign in_ready = rst_n && s1_adv;
   assign out_fire = s2_v && out_ready;

   // Compare ops report through the one-hot flags and leave data at zero.
   always_comb begin
      res_data = '0;
      res_flag = 3'b000;
      res_err  = 1'b0;
      res_cmp  = 1'b0;
      case (s1_op)
         OP_CPR: begin
            res_cmp = 1'b1;
            if (s1_a > s1_b)       res_flag = 3'b100;
            else if (s1_a == s1_b) res_flag = 3'b010;
            else                   res_flag = 3'b001;
         end
         OP_CPRS: begin
            res_cmp = 1'b1;
            if ($signed(s1_a) > $signed(s1_b)) res_flag = 3'b100;
            else if (s1_a == s1_b)             res_flag = 3'b010;
            else                               res_flag = 3'b001;
         end
         OP_AND:  res_data = s1_a & s1_b;
         OP_OR:   res_data = s1_a | s1_b;
         OP_XOR:  res_data = s1_a ^ s1_b;
         OP_NOTA: res_data = ~s1_a;
         OP_NOTB: res_data = ~s1_b;
         OP_NAND: res_data = ~(s1_a & s1_b);
         OP_NOR:  res_data = ~(s1_a | s1_b);
         OP_XNOR: res_data = ~(s1_a ^ s1_b);
         OP_ANDN: res_data = s1_a & ~s1_b;
         default: res_err  = 1'b1;
      endcase
      // Illegal opcodes deliberately report zero=0 even though data is zero.
      res_zero = res_cmp || (!res_err && (res_data == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v  <= 1'b0;
         s1_a  <= '0;
         s1_b  <= '0;
         s1_op <= '0;
      end else if (s1_adv) begin
         s1_v  <= in_valid;
         s1_a  <= in_a;
         s1_b  <= in_b;
         s1_op <= in_op;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v    <= 1'b0;
         s2_data <= '0;
         s2_flag <= 3'b000;
         s2_zero <= 1'b0;
         s2_err  <= 1'b0;
      end else if (s2_adv) begin
         s2_v    <= s1_v;
         s2_data <= res_data;
         s2_flag <= res_flag;
         s2_zero <= res_zero;
         s2_err  <= res_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (out_fire && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_ONE;
      end
   end

`ifdef LOGIC_UNIT_PARITY_EN
   logic s2_par;

   // Compare and illegal results carry zero data, so their parity is 0 automatically.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_par <= 1'b0;
      end else if (s2_adv) begin
         s2_par <= ^res_data;
      end
   end

   assign out_parity = s2_par;
`endif

   assign out_valid = s2_v;
   assign out_data  = s2_data;
   assign out_flag  = s2_flag;
   assign out_zero  = s2_zero;
   assign out_err   = s2_err;
   assign op_count  = cnt;

endmodule
